// File: rtl/switch_pkg.sv
// Shared types and constants for the switch output port and its byte FIFO.
package switch_pkg;

    localparam int DEPTH_DEFAULT = 64;
    localparam int BYTE_W        = 8;

    // Output port sequencing: wait for a packet, offer it, stream it, then idle one cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } port_state_e;

    // One FIFO entry: the packet byte plus its end-of-packet flag (9 bits).
    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/switch_byte_fifo.sv
// Show-ahead FIFO of byte+last entries with a synchronous flush.
module switch_byte_fifo
    import switch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        wr_en,
    input  fifo_entry_t wr_entry,
    input  logic        rd_en,
    output fifo_entry_t rd_entry,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fifo_entry_t       mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_wr;
    logic              do_rd;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    // Head entry is always visible without a read strobe.
    assign rd_entry = mem[rd_ptr];

    // Storage write.
    // NOTE: the array is deliberately not reset; entries are only ever read behind the
    // pointers, and a reset term would stop the array mapping onto RAM.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy for full/empty.
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_output_port.sv
// Packet-buffered output port: stores upstream bytes, releases only complete
// packets to the consumer, separates packets by a one-cycle gap, and flushes
// packets too large to ever fit in the buffer.
module switch_output_port
    import switch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic [BYTE_W-1:0] data_out,
    output logic              ready,
    input  logic              read,
    output logic              oversize_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    port_state_e   state;
    port_state_e   state_nxt;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] pkt_cnt_nxt;
    logic          discard;
    logic          fifo_full;
    logic          fifo_empty;
    fifo_entry_t   head;
    fifo_entry_t   wr_entry;
    logic          wr_fire;
    logic          fifo_wr;
    logic          rd_fire;
    logic          pkt_in;
    logic          pkt_out;
    logic          flush;
    logic          sending;

    // A full buffer holding no complete packet can never drain: it is an oversize packet.
    assign flush    = fifo_full && (pkt_cnt == '0);
    // While discarding the tail of an oversize packet, bytes are accepted and dropped.
    assign wr_ready = discard || !fifo_full;
    assign wr_fire  = wr_valid && wr_ready;
    assign fifo_wr  = wr_fire && !discard;
    assign sending  = (state == ST_READY) || (state == ST_SEND);
    assign rd_fire  = sending && read && !fifo_empty;
    assign pkt_in   = fifo_wr && wr_last;
    assign pkt_out  = rd_fire && head.last;
    assign wr_entry = '{last: wr_last, data: wr_data};

    switch_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .wr_en    (fifo_wr),
        .wr_entry (wr_entry),
        .rd_en    (rd_fire),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Complete-packet count: arrivals minus departures, cleared by a flush.
    // NOTE: every combinational output gets a default first, so no branch can leave
    // it unassigned and infer a latch.
    always_comb begin
        pkt_cnt_nxt = pkt_cnt;
        if (flush) begin
            pkt_cnt_nxt = '0;
        end else begin
            case ({pkt_in, pkt_out})
                2'b10:   pkt_cnt_nxt = pkt_cnt + 1'b1;
                2'b01:   pkt_cnt_nxt = pkt_cnt - 1'b1;
                default: pkt_cnt_nxt = pkt_cnt;
            endcase
        end
    end

    // Next state and consumer-facing outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        data_out  = '0;
        case (state)
            ST_IDLE: begin
                if (pkt_cnt != '0) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                ready    = 1'b1;
                data_out = head.data;
                if (rd_fire) begin
                    state_nxt = head.last ? ST_GAP : ST_SEND;
                end
            end
            ST_SEND: begin
                ready    = 1'b1;
                data_out = head.data;
                if (rd_fire && head.last) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                // Look at the updated count so a packet completed during the gap goes next.
                state_nxt = (pkt_cnt_nxt != '0) ? ST_READY : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, packet count, discard mode and error pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pkt_cnt      <= '0;
            discard      <= 1'b0;
            oversize_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pkt_cnt      <= pkt_cnt_nxt;
            oversize_err <= flush;
            if (flush) begin
                discard <= 1'b1;
            end else if (discard && wr_valid && wr_last) begin
                discard <= 1'b0;
            end
        end
    end

endmodule

// File: doc/switch_output_port.md
SWITCH_OUTPUT_PORT -- requirements
Module: switch_output_port

Interface
REQ-001 Parameter DEPTH, default 64, meaning: byte capacity of the internal FIFO; SHALL be a power of two, at least 4.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wr_valid  input  1  upstream byte valid.
REQ-005 wr_data  input  8  upstream packet byte.
REQ-006 wr_last  input  1  marks the final byte of an upstream packet.
REQ-007 wr_ready  output  1  port can accept a byte; a write occurs on a clock edge where wr_valid && wr_ready.
REQ-008 data_out  output  8  packet byte presented to the consumer.
REQ-009 ready  output  1  a complete packet is available or in transfer.
REQ-010 read  input  1  consumer pulls one byte per clock while high.
REQ-011 oversize_err  output  1  one-cycle pulse when a packet that exceeds DEPTH is flushed.

Function
REQ-012 wr_ready SHALL equal !full, combinationally, where full means DEPTH bytes are stored.
REQ-013 pkt_cnt SHALL count complete packets stored, width clog2(DEPTH)+1.
REQ-014 pkt_cnt: +1 on a write with wr_last; -1 when the last byte of a packet is consumed; unchanged when both happen in the same cycle.
REQ-015 FSM states: IDLE, READY, SEND, GAP.
REQ-016 IDLE: ready=0, data_out=0; go to READY on the next clock when pkt_cnt>0.
REQ-017 READY: ready=1; data_out shows the first byte of the head packet (show-ahead); go to SEND on the first clock with read=1, consuming that byte.
REQ-018 SEND: ready=1; each clock with read=1 consumes the current byte and presents the next.
REQ-019 SEND with read=0: stall; data_out SHALL hold its value and no byte is consumed.
REQ-020 Consuming the byte tagged last (in READY or SEND) SHALL go to GAP.
REQ-021 GAP lasts exactly 1 cycle: ready=0, data_out=0; then READY if pkt_cnt>0, else IDLE.
REQ-022 A packet written with wr_last during GAP SHALL be eligible in the following cycle.
REQ-023 read asserted while ready=0 SHALL be ignored.
REQ-024 Each FIFO entry SHALL store 9 bits: the data byte plus the last flag.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 Simultaneous read and write when full SHALL be allowed; wr_ready stays 0 that cycle per REQ-012.
REQ-027 Oversize packet: when full && pkt_cnt==0, the FIFO SHALL be flushed on the next clock.
REQ-028 On oversize flush: pulse oversize_err for 1 cycle; discard further upstream bytes (wr_ready=1) through and including the next wr_last.
REQ-029 Bytes discarded under REQ-028 SHALL NOT increment pkt_cnt.

Reset
REQ-030 Reset asserted SHALL immediately force: state=IDLE, pointers=0, pkt_cnt=0, discard mode off.
REQ-031 Output values during reset: ready=0, data_out=0, oversize_err=0, wr_ready=1.
REQ-032 Reset mid-packet SHALL drop all stored data, with no partial byte presented afterward.

Structure
REQ-033 Shared package switch_pkg SHALL hold the FSM state enum, the DEPTH default, and the byte-width constant (8).
REQ-034 Storage SHALL be a sub-module switch_byte_fifo: 9-bit wide, DEPTH deep, show-ahead, with full/empty flags.
REQ-035 The FSM, pkt_cnt and discard logic SHALL reside in switch_output_port.

Verification
REQ-036 Write 4-byte packet 0x11,0x22,0x33,0x44(last); hold read=1 -> ready rises 2 clocks after the last write; data_out gives 11,22,33,44 on consecutive clocks; then ready=0 for 1 cycle and the port goes IDLE.
REQ-037 Two 3-byte packets queued, read held high -> first packet, exactly one GAP cycle with ready=0, second packet, IDLE.
REQ-038 Drop read for 2 cycles after byte 0x22 is consumed -> data_out holds 0x33 during the stall; no byte is lost or duplicated.
REQ-039 DEPTH=64, push a 70-byte packet -> full at 64 bytes, oversize_err pulses once, bytes 65-70 discarded, pkt_cnt=0, next 2-byte packet delivered correctly.
REQ-040 Pulse reset during SEND after 2 of 5 bytes consumed -> ready=0 and data_out=0 immediately; post-reset only newly written packets appear.
REQ-041 Write a last byte in the same cycle the prior packet's last byte is consumed, with pkt_cnt=1 -> pkt_cnt stays 1; GAP is followed by READY.
